// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared encodings for the EX->MEM stage register: stage-state codes, stall/write-enable levels, NOP address.
package ex_mem_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PASS   = 2'b01,
        ST_BUBBLE = 2'b10,
        ST_HOLD   = 2'b11
    } stage_state_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam logic WE_ON   = 1'b1;
    localparam logic WE_OFF  = 1'b0;

    localparam int unsigned NOP_REG_ADDR = 0;

    function automatic logic is_stalled_state(input stage_state_t s);
        return (s == ST_BUBBLE) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/ex_mem_stage_reg_stall_ctr_sat.sv
// Saturating up-counter; sticks at all-ones until rst. Counts on the edge where i_inc is high.
// Latency: 1 cycle from i_inc to o_cnt. No backpressure.
module stall_ctr_sat #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register with flush, bubble/hold decode and multi-cycle accumulator loopback; optional stall counter under EX_MEM_STALL_CNT_EN.
// Latency: 1 cycle ex_* -> mem_*. Backpressure: stall[STAGE_IDX+1] holds MEM contents, stall[STAGE_IDX] alone inserts a bubble.
import ex_mem_stage_reg_pkg::*;

module ex_mem_stage_reg #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int CNT_W     = 2,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] acc_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [1:0]          stage_state,
    output logic [15:0]         stall_cycles
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
    } mem_bundle_t;

    stage_state_t      r_state;
    stage_state_t      w_next_state;
    mem_bundle_t       r_mem;
    mem_bundle_t       w_ex_bundle;
    mem_bundle_t       w_nop_bundle;
    logic [2*DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_ex_stop;
    logic              w_mem_stop;
    logic              w_take_ex;
    logic              w_loop_acc;
    logic              w_insert_nop;
    logic              w_unused_stall;

    // Only the EX and MEM bits matter; the rest of the vector is deliberately ignored.
    assign w_ex_stop      = (stall[STAGE_IDX]   == STOP);
    assign w_mem_stop     = (stall[STAGE_IDX+1] == STOP);
    assign w_unused_stall = ^stall;

    assign w_ex_bundle = '{valid: ex_valid, wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata,
                           hi: ex_hi, lo: ex_lo, whilo: ex_whilo};
    assign w_nop_bundle = '{valid: 1'b0, wd: ADDR_W'(NOP_REG_ADDR), wreg: WE_OFF, wdata: '0,
                            hi: '0, lo: '0, whilo: WE_OFF};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else if (!w_ex_stop) begin
            w_next_state = ex_valid ? ST_PASS : ST_IDLE;
        end else if (w_mem_stop) begin
            w_next_state = ST_HOLD;
        end else begin
            w_next_state = ST_BUBBLE;
        end
    end

    always_comb begin
        w_take_ex    = 1'b0;
        w_loop_acc   = 1'b0;
        w_insert_nop = 1'b0;
        if (!flush) begin
            if (!w_ex_stop) begin
                w_take_ex = 1'b1;
            end else begin
                w_loop_acc   = 1'b1;
                w_insert_nop = !w_mem_stop;
            end
        end
    end

    // Flush and reset both drop any in-flight multi-cycle result; no partial writeback.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_mem <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_take_ex) begin
            r_mem <= w_ex_bundle;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_loop_acc) begin
            r_acc <= acc_i;
            r_cnt <= cnt_i;
            if (w_insert_nop) begin
                r_mem <= w_nop_bundle;
            end
        end
    end

    assign mem_valid   = r_mem.valid;
    assign mem_wd      = r_mem.wd;
    assign mem_wreg    = r_mem.wreg;
    assign mem_wdata   = r_mem.wdata;
    assign mem_hi      = r_mem.hi;
    assign mem_lo      = r_mem.lo;
    assign mem_whilo   = r_mem.whilo;
    assign acc_o       = r_acc;
    assign cnt_o       = r_cnt;
    assign stage_state = r_state;

`ifdef EX_MEM_STALL_CNT_EN
    logic w_stall_inc;

    // Counts cycles that end stalled; flush lands in IDLE so it neither counts nor clears.
    assign w_stall_inc = !rst && is_stalled_state(w_next_state);

    stall_ctr_sat #(
        .W(16)
    ) u_stall_ctr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

endmodule
